// File: rtl/seq_shifter.sv
// Bit-serial right-shift / rotate unit with a start/done handshake.
// Each accepted request takes Cnt SHIFT cycles plus one DONE cycle. The working
// register is visible on Out at all times and holds the result after done.
module seq_shifter #(
  parameter int unsigned N = 16,
  parameter int unsigned C = 4,
  parameter int unsigned O = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] In,
  input  logic [C-1:0] Cnt,
  input  logic [O-1:0] Op,
  output logic [N-1:0] Out,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam logic [O-1:0] OpRor = O'(0);
  localparam logic [O-1:0] OpSrl = O'(1);
  localparam logic [O-1:0] OpSra = O'(2);
  localparam logic [O-1:0] OpRol = O'(3);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] data_q,  data_d;
  logic [C-1:0] rem_q,   rem_d;
  logic [O-1:0] op_q,    op_d;
  logic         err_q,   err_d;

  // One-bit move of the working register for the latched operation.
  function automatic logic [N-1:0] shift_step(input logic [N-1:0] d, input logic [O-1:0] op);
    logic [N-1:0] r;
    r = d;
    case (op)
      OpRor:   r = {d[0], d[N-1:1]};
      OpSrl:   r = {1'b0, d[N-1:1]};
      OpSra:   r = {d[N-1], d[N-1:1]};
      OpRol:   r = {d[N-2:0], d[N-1]};
      default: r = d;
    endcase
    return r;
  endfunction

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      data_q  <= '0;
      rem_q   <= '0;
      op_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath update: capture on start, step once per SHIFT cycle.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    op_d    = op_q;
    // A request that arrives while busy is dropped and flagged next cycle.
    err_d   = start && (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          data_d  = In;
          rem_d   = Cnt;
          op_d    = Op;
          state_d = (Cnt == '0) ? StDone : StShift;
        end
      end
      StShift: begin
        data_d = shift_step(data_q, op_q);
        rem_d  = rem_q - C'(1);
        if (rem_q == C'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    Out  = data_q;
    busy = (state_q != StIdle);
    done = (state_q == StDone);
    err  = err_q;
  end

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter: the driver predicts results and timing from
// plain arithmetic, the monitor checks every cycle one time unit after the edge.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] in_d = '0;
  logic [3:0]  cnt_d = '0;
  logic [1:0]  op_d = '0;
  logic [15:0] out_w;
  logic        busy_w, done_w, err_w;

  seq_shifter #(.N(16), .C(4), .O(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .In   (in_d),
    .Cnt  (cnt_d),
    .Op   (op_d),
    .Out  (out_w),
    .busy (busy_w),
    .done (done_w),
    .err  (err_w)
  );

  always #5 clk = ~clk;

  // Cycle k is the interval after the k-th rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] res;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   errq[$];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model of the operation window: busy over [acc_e, end_e], result res afterwards.
  int          free_at = 0;
  int          acc_e = -1;
  int          end_e = -1;
  logic [15:0] res = '0;

  function automatic logic [15:0] ref_res(input logic [15:0] x, input int k,
                                          input logic [1:0] op);
    int unsigned v, r;
    v = 32'(x);
    r = 0;
    case (op)
      2'd0: r = (v >> k) | (v << (16 - k));
      2'd1: r = v >> k;
      2'd2: begin
        r = v >> k;
        if (x[15]) r = r | ((32'hFFFF << (16 - k)) & 32'hFFFF);
      end
      default: r = (v << k) | (v >> (16 - k));
    endcase
    return r[15:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle of inputs for the next edge and update the prediction.
  task automatic drive(input bit r, input bit st, input logic [15:0] x,
                       input logic [3:0] k, input logic [1:0] op);
    int e;
    @(posedge clk);
    #2;
    e = cyc + 1;
    rst = r;
    start = st;
    in_d = x;
    cnt_d = k;
    op_d = op;
    if (r) begin
      q.delete();
      errq.delete();
      res = '0;
      acc_e = -1;
      end_e = -1;
      free_at = e + 1;
    end else if (st) begin
      if (e >= free_at) begin
        acc_e = e;
        end_e = e + int'(k);
        res = ref_res(x, int'(k), op);
        q.push_back('{res, end_e});
        free_at = end_e + 2;
      end else begin
        errq.push_back(e);
      end
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'($urandom), 4'($urandom), 2'($urandom));
  endtask

  // Issue a request and idle until the earliest cycle a new one is accepted.
  task automatic run(input logic [15:0] x, input logic [3:0] k, input logic [1:0] op);
    drive(1'b0, 1'b1, x, k, op);
    repeat (int'(k) + 1) idle();
  endtask

  // Monitor: busy, err, done timing and results, and Out holding when idle.
  int m_cur;
  bit exp_err, exp_done;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (chk_en) begin
        m_cur = cyc;
        chk("busy", 32'(busy_w), 32'((m_cur >= acc_e) && (m_cur <= end_e)));
        exp_err = 1'b0;
        if (errq.size() > 0 && errq[0] == m_cur) begin
          exp_err = 1'b1;
          void'(errq.pop_front());
        end
        chk("err", 32'(err_w), 32'(exp_err));
        exp_done = (q.size() > 0) && (q[0].cyc == m_cur);
        chk("done", 32'(done_w), 32'(exp_done));
        if (exp_done) begin
          chk("result", 32'(out_w), 32'(q[0].res));
          void'(q.pop_front());
        end
        if (m_cur > end_e) chk("out_hold", 32'(out_w), 32'(res));
      end
    end
  end

  initial begin
    repeat (3) drive(1'b1, 1'b0, '0, '0, '0);
    chk_en = 1'b1;
    idle();

    // Directed cases.
    run(16'h8001, 4'd1, 2'd0);
    idle(); idle();
    run(16'hF0F0, 4'd4, 2'd1);
    repeat (5) idle();
    run(16'h8000, 4'd15, 2'd2);
    run(16'h4000, 4'd14, 2'd2);
    run(16'h1234, 4'd4, 2'd3);
    run(16'hABCD, 4'd0, 2'($urandom));
    idle();

    // Start while busy: dropped, err pulses, first op unaffected.
    drive(1'b0, 1'b1, 16'h00FF, 4'd8, 2'd1);
    idle(); idle();
    drive(1'b0, 1'b1, 16'h1111, 4'd1, 2'd3);
    repeat (6) idle();
    idle();

    // Reset mid-shift discards the operation.
    drive(1'b0, 1'b1, 16'hFFFF, 4'd10, 2'd1);
    repeat (4) idle();
    drive(1'b1, 1'b0, '0, '0, '0);
    run(16'h0001, 4'd1, 2'd3);
    idle();

    // Random traffic with occasional resets.
    repeat (800) begin
      if ($urandom_range(0, 99) == 0) begin
        drive(1'b1, 1'b0, '0, '0, '0);
      end else begin
        drive(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 4'($urandom), 2'($urandom));
      end
    end

    repeat (20) idle();
    chk("sb_empty", 32'(q.size()), 32'd0);
    chk("errq_empty", 32'(errq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
